// File: rtl/dma_pkg.sv
// Shared types and defaults for the byte-stream DMA: FSM encoding, FIFO entry layout,
// default ring placement and a lane-mask helper for partially packed words.
package dma_pkg;

   localparam logic [31:0] DEF_BASE_ADR   = 32'h0000_0000;
   localparam int          DEF_RING_WORDS = 2048;
   localparam int          DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_GAP  = 2'd2
   } dma_state_t;

   typedef struct packed {
      logic [31:0] dat;
      logic [3:0]  sel;
   } dma_entry_t;

   // Lanes 0..nbytes-1 enabled; 0 or 4 bytes both mean a full word.
   function automatic logic [3:0] lane_mask(input logic [2:0] nbytes);
      case (nbytes)
         3'd1:    lane_mask = 4'b0001;
         3'd2:    lane_mask = 4'b0011;
         3'd3:    lane_mask = 4'b0111;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/wb_word_fifo.sv
// First-word-fall-through FIFO of packed {dat, sel} entries with occupancy count
// and asynchronous clear of the pointers.
module wb_word_fifo
   import dma_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     push,
   input  dma_entry_t               push_data,
   input  logic                     pop,
   output dma_entry_t               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   dma_entry_t       mem [DEPTH];
   logic [AW-1:0]    wr_idx_reg;
   logic [AW-1:0]    rd_idx_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_idx_reg];

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_idx_reg <= '0;
         rd_idx_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_idx_reg <= wr_idx_reg + 1'b1;
         if (do_pop)  rd_idx_reg <= rd_idx_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset so it can map onto plain memory.
   always_ff @(posedge wb_clk_i) begin
      if (do_push) mem[wr_idx_reg] <= push_data;
   end

endmodule

// File: rtl/wb_bytestream_dma.sv
// Packs an 8-bit stream into 32-bit words and writes them as single Wishbone cycles
// into a circular region, never passing the reader's pointer.
module wb_bytestream_dma
   import dma_pkg::*;
#(
   parameter logic [31:0] BASE_ADR   = DEF_BASE_ADR,
   parameter int          RING_WORDS = DEF_RING_WORDS,
   parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic [7:0]   st_dat_i,
   input  logic         st_valid_i,
   output logic         st_ready_o,
   input  logic         flush_i,
   input  logic [10:0]  rd_ptr_i,
   output logic [10:0]  wr_ptr_o,
   output logic         overrun_o,
   output logic [31:0]  wbm_adr_o,
   output logic [31:0]  wbm_dat_o,
   output logic [3:0]   wbm_sel_o,
   output logic         wbm_cyc_o,
   output logic         wbm_stb_o,
   output logic         wbm_we_o,
   input  logic         wbm_ack_i
);

   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [10:0] PTR_MASK = 11'(RING_WORDS - 1);

   logic [1:0]    bc_reg, bc_next;
   logic [2:0]    bc_after;
   logic [31:0]   stage_reg, stage_next;
   logic          flush_pend_reg, flush_pend_next;
   logic          ready_reg, ready_next;
   logic          flush_req, accept;
   logic          push, pop;
   dma_entry_t    push_entry, head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count, count_next;

   dma_state_t    state_reg, state_next;
   logic [10:0]   wr_ptr_reg, wr_ptr_next;
   logic          overrun_reg, overrun_next;
   logic          cyc_reg, cyc_next;
   logic [31:0]   adr_reg, adr_next;
   logic [31:0]   dat_reg, dat_next;
   logic [3:0]    sel_reg, sel_next;
   logic          ring_full;

   // A flush that meets a full FIFO is parked until a slot frees; bytes wait behind it.
   assign flush_req  = flush_i || flush_pend_reg;
   assign st_ready_o = ready_reg && !(flush_req && fifo_full);
   assign accept     = st_valid_i && st_ready_o;

   always_comb begin
      stage_next      = stage_reg;
      bc_after        = {1'b0, bc_reg};
      bc_next         = bc_reg;
      flush_pend_next = 1'b0;
      push            = 1'b0;
      push_entry      = '0;
      if (accept) begin
         stage_next[{bc_reg, 3'b000} +: 8] = st_dat_i;
         bc_after = bc_after + 3'd1;
      end
      if (bc_after == 3'd4) begin
         push       = 1'b1;
         push_entry = '{dat: stage_next, sel: 4'b1111};
         stage_next = '0;
         bc_next    = 2'd0;
      end else if (flush_req && bc_after != 3'd0) begin
         if (!fifo_full) begin
            push       = 1'b1;
            push_entry = '{dat: stage_next, sel: lane_mask(bc_after)};
            stage_next = '0;
            bc_next    = 2'd0;
         end else begin
            flush_pend_next = 1'b1;
            bc_next         = bc_after[1:0];
         end
      end else begin
         bc_next = bc_after[1:0];
      end
   end

   always_comb begin
      count_next = fifo_count;
      if (push && !pop)      count_next = fifo_count + 1'b1;
      else if (!push && pop) count_next = fifo_count - 1'b1;
      ready_next = (bc_next != 2'd3) || (count_next != CW'(FIFO_DEPTH));
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         bc_reg         <= 2'd0;
         stage_reg      <= '0;
         flush_pend_reg <= 1'b0;
         ready_reg      <= 1'b0;
      end else begin
         bc_reg         <= bc_next;
         stage_reg      <= stage_next;
         flush_pend_reg <= flush_pend_next;
         ready_reg      <= ready_next;
      end
   end

   wb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign ring_full = (((wr_ptr_reg + 11'd1) & PTR_MASK) == (rd_ptr_i & PTR_MASK));

   always_comb begin
      state_next   = state_reg;
      wr_ptr_next  = wr_ptr_reg;
      overrun_next = overrun_reg;
      cyc_next     = cyc_reg;
      adr_next     = adr_reg;
      dat_next     = dat_reg;
      sel_next     = sel_reg;
      pop          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (ring_full) begin
                  overrun_next = 1'b1;
               end else begin
                  state_next = ST_BUS;
                  cyc_next   = 1'b1;
                  adr_next   = BASE_ADR + {19'd0, wr_ptr_reg, 2'b00};
                  dat_next   = head.dat;
                  sel_next   = head.sel;
               end
            end
         end
         ST_BUS: begin
            if (wbm_ack_i) begin
               pop         = 1'b1;
               wr_ptr_next = (wr_ptr_reg + 11'd1) & PTR_MASK;
               cyc_next    = 1'b0;
               state_next  = ST_GAP;
            end
         end
         ST_GAP:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg   <= ST_IDLE;
         wr_ptr_reg  <= '0;
         overrun_reg <= 1'b0;
         cyc_reg     <= 1'b0;
         adr_reg     <= BASE_ADR;
         dat_reg     <= '0;
         sel_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         wr_ptr_reg  <= wr_ptr_next;
         overrun_reg <= overrun_next;
         cyc_reg     <= cyc_next;
         adr_reg     <= adr_next;
         dat_reg     <= dat_next;
         sel_reg     <= sel_next;
      end
   end

   assign wr_ptr_o  = wr_ptr_reg;
   assign overrun_o = overrun_reg;
   assign wbm_adr_o = adr_reg;
   assign wbm_dat_o = dat_reg;
   assign wbm_sel_o = sel_reg;
   assign wbm_cyc_o = cyc_reg;
   assign wbm_stb_o = cyc_reg;
   assign wbm_we_o  = cyc_reg;

endmodule
